// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory with WAIT_CYCLES wait states and a registered one-cycle ack.
// Optional macro MEM_BOUNDS_CHECK_EN: flag, suppress and zero-fill out-of-range accesses.
module data_mem_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      mem [DEPTH];

    logic             we_q;
    logic             oob_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;

    logic             req_oob;
    logic             acc_en;
    logic             acc_we;
    logic             acc_oob;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_data;

`ifdef MEM_BOUNDS_CHECK_EN
    assign req_oob = |addr_i[31:IDX_W+2];
`else
    logic unused_addr_hi;
    assign req_oob        = 1'b0;
    assign unused_addr_hi = |addr_i[31:IDX_W+2];
`endif
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_i[1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    cnt_nxt = '0;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        acc_en    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                    acc_en    = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-wait accesses happen on the accept edge, so they use the live request fields.
    assign acc_we   = (state == IDLE) ? we_i                 : we_q;
    assign acc_oob  = (state == IDLE) ? req_oob              : oob_q;
    assign acc_idx  = (state == IDLE) ? addr_i[IDX_W+1:2]    : idx_q;
    assign acc_data = (state == IDLE) ? data_i               : wdata_q;

    always_ff @(posedge clk_i) begin
        if (state == IDLE && req_i) begin
            we_q    <= we_i;
            oob_q   <= req_oob;
            idx_q   <= addr_i[IDX_W+1:2];
            wdata_q <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc_en && acc_we && !acc_oob)
            mem[acc_idx] <= acc_data;
    end

    // Ack and error land one cycle after RESP, in the first IDLE cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            data_o <= 32'h0;
            ack_o  <= 1'b0;
            busy_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ack_o  <= (state == RESP);
            err_o  <= (state == RESP) && oob_q;
            busy_o <= (state_nxt != IDLE);
            if (acc_en && !acc_we)
                data_o <= acc_oob ? 32'h0 : mem[acc_idx];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;
    localparam int W     = 2;
    localparam int DEPTH = 128;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, we_i;
    logic [31:0] addr_i, data_i, data_o;
    logic        ack_o, busy_o, err_o;

    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ack0, busy0, err0;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_dout;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .ack_o(ack_o), .busy_o(busy_o), .err_o(err_o)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .data_i(wdata0), .data_o(rdata0), .ack_o(ack0), .busy_o(busy0), .err_o(err0)
    );

    initial forever #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic mdl_oob(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
        return (a >> 2) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    task automatic mdl_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        exp_err = mdl_oob(a);
        if (we) begin
            if (!exp_err) mem_m[idx] = d;
        end else begin
            exp_dout = exp_err ? 32'h0 : mem_m[idx];
        end
        exp_rd = exp_dout;
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic busy_first);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = a; data_i = d;
        @(posedge clk_i);
        #1;
        req_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom; data_i = $urandom;
        @(negedge clk_i);
        busy_first = busy_o;
        lat = -1; rd = 'x; err = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (ack_o) begin
                lat = n; rd = data_o; err = err_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; req_i = 0; we_i = 0; addr_i = 0; data_i = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({ack_o, busy_o, err_o, data_o} !== 35'h0)
            $display("FAIL reset_outputs: ack=%b busy=%b err=%b data=%h, want all 0", ack_o, busy_o, err_o, data_o);
        else n_pass++;
        n_checks++;
        if ({ack0, busy0, err0, rdata0} !== 35'h0)
            $display("FAIL reset_outputs_w0: ack=%b busy=%b err=%b data=%h, want all 0", ack0, busy0, err0, rdata0);
        else n_pass++;
        rst_i = 1'b1;
        exp_dout = 32'h0;
    endtask

    task automatic test_fill();
        logic [31:0] rd, er_d; logic err, bf, exp_err; int lat, bad;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 32'(i * 4), $urandom, rd, err, lat, bf);
            mdl_op(1'b1, 32'(i * 4), u_dut.acc_data, er_d, exp_err);
        end
        // Re-write with bench-owned data so the model never depends on DUT internals.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            access(1'b1, 32'(i * 4), d, rd, err, lat, bf);
            mdl_op(1'b1, 32'(i * 4), d, er_d, exp_err);
            if (lat != W + 1 || rd !== er_d) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL fill: %0d writes had wrong latency or data_o, want 0", bad);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, er; logic err, bf, ee; int lat;
        access(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, rd, err, lat, bf);
        mdl_op(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, er, ee);
        n_checks++;
        if (lat != W + 1 || bf !== 1'b1)
            $display("FAIL write_latency: lat=%0d busy=%b, want lat=%0d busy=1", lat, bf, W + 1);
        else n_pass++;
        n_checks++;
        if (rd !== er) $display("FAIL write_holds_data_o: got %h want %h", rd, er);
        else n_pass++;
        access(1'b0, 32'h0000_0008, 32'h0, rd, err, lat, bf);
        mdl_op(1'b0, 32'h0000_0008, 32'h0, er, ee);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || lat != W + 1)
            $display("FAIL read_back: data=%h lat=%0d, want DEADBEEF lat=%0d", rd, lat, W + 1);
        else n_pass++;
        n_checks++;
        if (busy_o !== 1'b0 || err !== 1'b0)
            $display("FAIL ack_cycle_flags: busy=%b err=%b, want 0 0", busy_o, err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t1, t2; logic [31:0] d1, d2;
        t1 = -1; t2 = -1; d1 = 'x; d2 = 'x;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4;
        @(posedge clk_i);
        #1 addr_i = 32'hC;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (ack_o) begin t1 = cyc; d1 = data_o; break; end
        end
        @(posedge clk_i);
        #1 req_i = 1'b0; addr_i = $urandom;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (ack_o) begin t2 = cyc; d2 = data_o; break; end
        end
        exp_dout = mem_m[3];
        n_checks++;
        if (t1 < 0 || t2 < 0 || t2 - t1 != W + 2)
            $display("FAIL b2b_spacing: t1=%0d t2=%0d, want spacing %0d", t1, t2, W + 2);
        else n_pass++;
        n_checks++;
        if (d1 !== mem_m[1] || d2 !== mem_m[3])
            $display("FAIL b2b_data: got %h %h want %h %h", d1, d2, mem_m[1], mem_m[3]);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int acks; logic [31:0] rd, er, d0; logic err, bf, ee; int lat;
        acks = 0; d0 = 'x;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL busy_during_wait: got %b want 1", busy_o);
        else n_pass++;
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; data_i = ~mem_m[8];
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk_i);
            if (ack_o) begin acks++; d0 = data_o; end
        end
        exp_dout = mem_m[0];
        n_checks++;
        if (acks != 1 || d0 !== mem_m[0])
            $display("FAIL busy_ignore_ack: acks=%0d data=%h, want 1 %h", acks, d0, mem_m[0]);
        else n_pass++;
        access(1'b0, 32'h20, 32'h0, rd, err, lat, bf);
        mdl_op(1'b0, 32'h20, 32'h0, er, ee);
        n_checks++;
        if (rd !== er) $display("FAIL busy_ignore_mem: got %h want %h", rd, er);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int acks; logic [31:0] rd, er; logic err, bf, ee; int lat;
        acks = 0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; data_i = ~mem_m[4];
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        n_checks++;
        if ({ack_o, busy_o, err_o, data_o} !== 35'h0)
            $display("FAIL abort_outputs: ack=%b busy=%b err=%b data=%h, want all 0", ack_o, busy_o, err_o, data_o);
        else n_pass++;
        exp_dout = 32'h0;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
        end
        n_checks++;
        if (acks != 0) $display("FAIL abort_no_ack: acks=%0d want 0", acks);
        else n_pass++;
        access(1'b0, 32'h10, 32'h0, rd, err, lat, bf);
        mdl_op(1'b0, 32'h10, 32'h0, er, ee);
        n_checks++;
        if (rd !== er) $display("FAIL abort_no_write: got %h want %h", rd, er);
        else n_pass++;
    endtask

    task automatic test_wait0();
        logic [31:0] d, got;
        int lat, busy_cnt;
        d = $urandom;
        for (int op = 0; op < 2; op++) begin
            @(negedge clk_i);
            req0 = 1'b1; we0 = (op == 0); addr0 = 32'h8; wdata0 = d;
            @(posedge clk_i);
            #1 req0 = 1'b0; wdata0 = $urandom;
            lat = -1; busy_cnt = 0; got = 'x;
            for (int n = 0; n < 5; n++) begin
                @(negedge clk_i);
                if (busy0) busy_cnt++;
                if (ack0 && lat < 0) begin lat = n; got = rdata0; end
            end
            n_checks++;
            if (lat != 1 || busy_cnt != 1)
                $display("FAIL w0_timing op%0d: lat=%0d busy_cycles=%0d, want 1 1", op, lat, busy_cnt);
            else n_pass++;
        end
        n_checks++;
        if (got !== d) $display("FAIL w0_read: got %h want %h", got, d);
        else n_pass++;
    endtask

    task automatic test_bounds();
        logic [31:0] rd, er, x; logic err, bf, ee; int lat;
        x = ~mem_m[0];
        access(1'b1, 32'h0000_0200, x, rd, err, lat, bf);
        mdl_op(1'b1, 32'h0000_0200, x, er, ee);
        n_checks++;
        if (err !== ee || lat != W + 1)
            $display("FAIL bounds_write_err: err=%b lat=%0d, want %b %0d", err, lat, ee, W + 1);
        else n_pass++;
        access(1'b0, 32'h0, 32'h0, rd, err, lat, bf);
        mdl_op(1'b0, 32'h0, 32'h0, er, ee);
        n_checks++;
        if (rd !== er || err !== 1'b0)
            $display("FAIL bounds_mem0: data=%h err=%b, want %h 0", rd, err, er);
        else n_pass++;
        access(1'b0, 32'h0000_0200, 32'h0, rd, err, lat, bf);
        mdl_op(1'b0, 32'h0000_0200, 32'h0, er, ee);
        n_checks++;
        if (rd !== er || err !== ee)
            $display("FAIL bounds_read: data=%h err=%b, want %h %b", rd, err, er, ee);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, er; logic we, err, bf, ee; int lat;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom);
            d  = $urandom;
            a  = {($urandom_range(0, 9) == 0) ? 23'($urandom) : 23'h0,
                  7'($urandom_range(0, 15)), 2'($urandom)};
            access(we, a, d, rd, err, lat, bf);
            mdl_op(we, a, d, er, ee);
            n_checks++;
            if (rd !== er || err !== ee || lat != W + 1)
                $display("FAIL random[%0d] we=%b a=%h: data=%h err=%b lat=%0d, want %h %b %0d",
                         i, we, a, rd, err, lat, er, ee, W + 1);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_wait0();
        test_bounds();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
